// File: rtl/wb_grf.sv
// Write-back stage endpoint: 32 x DATA_W register file with same-cycle write-to-read bypass,
// registered commit trace and retired-instruction counter.
module wb_grf #(
    parameter int unsigned DATA_W   = 32,
    parameter bit          TRACE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wb_pc,
    input  logic [31:0]       wb_instr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [4:0]        wb_wreg,
    input  logic              wb_we,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              trace_valid,
    output logic [31:0]       trace_pc,
    output logic [4:0]        trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic [31:0]       retire_count
);

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    logic              trace_valid_q, trace_valid_d;
    logic [31:0]       trace_pc_q, trace_pc_d;
    logic [4:0]        trace_reg_q, trace_reg_d;
    logic [DATA_W-1:0] trace_data_q, trace_data_d;
    logic [31:0]       retire_count_q, retire_count_d;

    logic commit;

    // $0 is never written, so regs_q[0] stays at its reset value of zero.
    assign commit = wb_we && (wb_wreg != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wb_wreg] = wb_wdata;
        end
    end

    always_comb begin
        rs_data = '0;
        if (rs_addr != 5'd0) begin
            rs_data = (commit && (rs_addr == wb_wreg)) ? wb_wdata : regs_q[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != 5'd0) begin
            rt_data = (commit && (rt_addr == wb_wreg)) ? wb_wdata : regs_q[rt_addr];
        end
    end

    always_comb begin
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_reg_d   = trace_reg_q;
        trace_data_d  = trace_data_q;
        if (TRACE_EN) begin
            trace_valid_d = commit;
            if (commit) begin
                trace_pc_d   = wb_pc;
                trace_reg_d  = wb_wreg;
                trace_data_d = wb_wdata;
            end
        end else begin
            trace_pc_d   = '0;
            trace_reg_d  = '0;
            trace_data_d = '0;
        end
    end

    // Bubbles are all-zero words; every other instruction retires, writer or not.
    always_comb begin
        retire_count_d = retire_count_q;
        if (wb_instr != 32'h0) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q         <= '{default: '0};
            trace_valid_q  <= 1'b0;
            trace_pc_q     <= '0;
            trace_reg_q    <= '0;
            trace_data_q   <= '0;
            retire_count_q <= '0;
        end else begin
            regs_q         <= regs_d;
            trace_valid_q  <= trace_valid_d;
            trace_pc_q     <= trace_pc_d;
            trace_reg_q    <= trace_reg_d;
            trace_data_q   <= trace_data_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign trace_valid  = trace_valid_q;
    assign trace_pc     = trace_pc_q;
    assign trace_reg    = trace_reg_q;
    assign trace_data   = trace_data_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: per-cycle expected outputs are queued when a WB cycle is driven
// and compared one cycle later; read ports are checked combinationally against a bench model.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_pc, wb_instr, wb_wdata;
    logic [4:0]  wb_wreg;
    logic        wb_we;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [31:0] retire_count;

    wb_grf #(
        .DATA_W  (32),
        .TRACE_EN(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_pc       (wb_pc),
        .wb_instr    (wb_instr),
        .wb_wdata    (wb_wdata),
        .wb_wreg     (wb_wreg),
        .wb_we       (wb_we),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_reg   (trace_reg),
        .trace_data  (trace_data),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Bench model of architectural state
    logic [31:0] m_regs [32];
    logic        m_tv;
    logic [31:0] m_pc, m_data, m_cnt;
    logic [4:0]  m_rg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic c;
        c = wb_we && (wb_wreg != 5'd0);
        if (a == 5'd0) return 32'h0;
        if (c && (a == wb_wreg)) return wb_wdata;
        return m_regs[a];
    endfunction

    // Drive one WB cycle at the negedge, check reads combinationally, queue expected outputs.
    task automatic step(input logic rst, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        logic c;
        @(negedge clk);
        reset = rst; wb_we = we; wb_wreg = wreg; wb_wdata = wdata;
        wb_pc = pc; wb_instr = instr; rs_addr = ra; rt_addr = rb;
        #1;
        if (!rst) begin
            check("rs_data", rs_data, model_read(ra));
            check("rt_data", rt_data, model_read(rb));
        end
        c = we && (wreg != 5'd0);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_tv = 1'b0; m_pc = 32'h0; m_rg = 5'h0; m_data = 32'h0; m_cnt = 32'h0;
        end else begin
            if (c) begin
                m_regs[wreg] = wdata;
                m_pc = pc; m_rg = wreg; m_data = wdata;
            end
            m_tv = c;
            if (instr != 32'h0) m_cnt = m_cnt + 32'd1;
        end
        e.tv = m_tv; e.pc = m_pc; e.rg = m_rg; e.data = m_data; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trace_valid", {31'h0, trace_valid}, {31'h0, e.tv});
            check("trace_pc", trace_pc, e.pc);
            check("trace_reg", {27'h0, trace_reg}, {27'h0, e.rg});
            check("trace_data", trace_data, e.data);
            check("retire_count", retire_count, e.cnt);
        end
    end

    initial begin
        reset = 1'b1; wb_we = 1'b0; wb_wreg = '0; wb_wdata = '0;
        wb_pc = '0; wb_instr = '0; rs_addr = '0; rt_addr = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_tv = 1'b0; m_pc = '0; m_rg = '0; m_data = '0; m_cnt = '0;

        // Reset with a pending write that must be dropped
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd0);
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd1);

        // Basic write then read
        step(1'b0, 1'b1, 5'd8, 32'h1234_5678, 32'h0000_3000, 32'h3408_5678, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0000_3004, 32'h0, 5'd8, 5'd0);

        // Bypass on both ports
        step(1'b0, 1'b1, 5'd9, 32'h0000_0001, 32'h0000_3008, 32'h3409_0001, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'h0000_0002, 32'h0000_300C, 32'h3409_0002, 5'd9, 5'd9);

        // $0 write discarded, not traced, still retires
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3010, 32'h3400_FFFF, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9);

        // Bubbles then non-writing stores
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 5'd8, 32'hAAAA_5555, 32'h0000_3020 + 32'(4 * i), 32'hAC08_0000,
                 5'd8, 5'd9);

        // Back-to-back commits, last write to $3 wins
        step(1'b0, 1'b1, 5'd3, 32'd1, 32'h0000_3100, 32'h3403_0001, 5'd3, 5'd4);
        step(1'b0, 1'b1, 5'd3, 32'd2, 32'h0000_3104, 32'h3403_0002, 5'd3, 5'd4);
        step(1'b0, 1'b1, 5'd4, 32'd3, 32'h0000_3108, 32'h3404_0003, 5'd3, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4);

        // Random traffic
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 $urandom, (($urandom_range(0, 3) == 0) ? 32'h0 : $urandom),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Reset mid-stream with an in-flight write
        step(1'b0, 1'b1, 5'd3, 32'h5555_0003, 32'h0000_3200, 32'h3403_5555, 5'd3, 5'd0);
        step(1'b1, 1'b1, 5'd3, 32'h7777_0003, 32'h0000_3204, 32'h3403_7777, 5'd3, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4);
        step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd9);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0 pending entries", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage endpoint and general register file for the 5-stage MIPS pipeline.
- Consumes the registered MEM/WB stage fields and commits results into 32 x 32-bit registers.
- Provides two combinational read ports to the decode stage, with internal write-to-read bypass.
- Emits a registered commit trace (PC, register, data) and a retired-instruction counter for grading and debug.

Parameters:
- DATA_W, 32, register and data width.
- TRACE_EN, 1, when 0, trace_valid is held at 0 and the trace_* outputs are held at 0.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wb_pc  in  32  PC of the instruction in WB.
- wb_instr  in  32  instruction word in WB; 32'h0000_0000 is a bubble/nop.
- wb_wdata  in  DATA_W  write-back data.
- wb_wreg  in  5  destination register number.
- wb_we  in  1  write enable for this WB instruction.
- rs_addr  in  5  read port A address (decode stage).
- rt_addr  in  5  read port B address.
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- trace_valid  out  1  one-cycle commit strobe, registered.
- trace_pc  out  32  PC of the committed instruction.
- trace_reg  out  5  register written.
- trace_data  out  DATA_W  value written.
- retire_count  out  32  count of non-bubble instructions that have passed WB.

Behaviour:
- Reset: on posedge with reset=1, all 32 registers, trace_valid, trace_pc, trace_reg, trace_data and retire_count are cleared to 0.
  - Reset dominates; no commit, trace or count occurs in that cycle even if wb_we=1.
- Commit condition C = wb_we && (wb_wreg != 0). On posedge with reset=0 and C=1, reg[wb_wreg] <= wb_wdata.
- $0 is hard-wired to 0:
  - A write with wb_wreg=0 is discarded.
  - A $0 write produces no trace.
- Read ports are combinational, evaluated independently per port. For port A:
  - rs_addr==0 -> 0.
  - Else if C=1 and rs_addr==wb_wreg -> wb_wdata (same-cycle bypass, so decode sees the value being written this cycle).
  - Else -> reg[rs_addr].
  - Port B is identical with rt_addr.
  - Both ports may hit the bypass simultaneously.
- Trace, active when TRACE_EN=1:
  - On posedge with reset=0, trace_valid <= C.
  - When C=1: trace_pc <= wb_pc, trace_reg <= wb_wreg, trace_data <= wb_wdata.
  - When C=0: trace_pc/reg/data hold their previous values.
  - Latency: the trace appears exactly 1 cycle after the WB cycle.
  - Back-to-back commits produce back-to-back strobes with no gap.
- Retire counter:
  - On posedge with reset=0 and wb_instr != 0, retire_count <= retire_count + 1.
  - Counts regardless of wb_we (e.g. sw, beq, j retire without writing).
  - Wraps from 32'hFFFF_FFFF to 0 with no flag.
- Repeated writes to the same register on consecutive cycles: each is committed and traced in order; the last one wins.
- Reset asserted mid-stream: any in-flight WB data is dropped and the register file reads 0 on the next cycle.
- No X propagation: all outputs are defined from the first posedge with reset=1 onward.

Test Plan:
- Reset: reset=1 for 2 cycles with wb_we=1, wb_wreg=5, wb_wdata=32'hDEAD_BEEF -> rs_data for addr 5 is 0, trace_valid=0, retire_count=0.
- Basic write/read: wb_we=1, wb_wreg=8, wb_wdata=32'h1234_5678, wb_pc=32'h0000_3000, wb_instr=32'h3408_5678 -> next cycle rs_addr=8 reads 32'h1234_5678; trace_valid=1, trace_pc=32'h0000_3000, trace_reg=8; retire_count=1.
- Bypass: reg[9]=32'h0000_0001, then in the same cycle wb_we=1, wb_wreg=9, wb_wdata=32'h0000_0002, rs_addr=rt_addr=9 -> both ports read 32'h0000_0002 combinationally in that cycle.
- $0 protection: wb_we=1, wb_wreg=0, wb_wdata=32'hFFFF_FFFF, rs_addr=0 -> rs_data=0 in that cycle and after; trace_valid stays 0; retire_count increments only if wb_instr != 0.
- Bubbles and non-writers: 3 cycles with wb_instr=0, then 2 cycles with wb_instr=32'hAC08_0000 (sw) and wb_we=0 -> retire_count rises by 2; no trace strobes; register contents unchanged.
- Back-to-back and reset mid-stream: commits to $3=1, $3=2, $4=3 on consecutive cycles -> 3 consecutive trace strobes in order and reg[3]=2; then reset=1 for 1 cycle -> reg[3]=0, retire_count=0, trace_valid=0 the following cycle.
